gb_mem_arbiter: RTL and testbench



---
 rtl/gb_mem_pkg.sv | 10 +
 rtl/gb_mem_if.sv | 23 ++
 rtl/rom_word_buf.sv | 58 +++++
 rtl/gb_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_gb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gb_mem_pkg.sv
// Shared types and defaults for the Game Boy memory arbiter.
package gb_mem_pkg;

    localparam int          MEM_AW_DEF  = 25;
    localparam logic [24:0] BK_BASE_DEF = 25'h1F0_0000;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {G_ROM, G_DL, G_BK} grant_t;

endpackage

// File: rtl/gb_mem_if.sv
// 16-bit external memory port shared by ROM fetch, download and backup traffic.
interface gb_mem_if
    import gb_mem_pkg::*;
#(
    parameter int MEM_AW = MEM_AW_DEF
);
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_req;
    logic              mem_we;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_addr, mem_req, mem_we, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_req, mem_we, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/rom_word_buf.sv
// One-word ROM read buffer: tag compare, byte select and download invalidation.
module rom_word_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic [22:0] rom_addr,
    input  logic        rom_rd,
    input  logic        fill,
    input  logic [21:0] fill_tag,
    input  logic [15:0] fill_word,
    input  logic        inval,
    input  logic [23:0] inval_addr,
    output logic        miss,
    output logic [7:0]  rom_di,
    output logic        rom_ready
);
    logic [21:0] tag;
    logic [15:0] word;
    logic        valid;
    logic        hit;
    logic        inval_hit;

    assign hit  = rom_rd && valid && (tag == rom_addr[22:1]);
    assign miss = rom_rd && !hit;

    // Compare against the tag that will be current after this edge, so a
    // download landing on a word being filled right now still kills it.
    assign inval_hit = inval && (inval_addr == {2'b00, (fill ? fill_tag : tag)});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
        end else if (inval_hit) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
        end
    end

    // NOTE: tag and word carry no reset; valid alone decides whether they mean anything.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag  <= fill_tag;
            word <= fill_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_di    <= 8'h00;
            rom_ready <= 1'b0;
        end else begin
            rom_ready <= hit;
            if (hit) begin
                rom_di <= rom_addr[0] ? word[15:8] : word[7:0];
            end
        end
    end
endmodule

// File: rtl/gb_mem_arbiter.sv
// Sequences ROM fetch, ROM download and backup-RAM accesses onto one memory port.
module gb_mem_arbiter
    import gb_mem_pkg::*;
#(
    parameter int              MEM_AW  = MEM_AW_DEF,
    parameter logic [MEM_AW-1:0] BK_BASE = MEM_AW'(BK_BASE_DEF)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [22:0] rom_addr,
    input  logic        rom_rd,
    output logic [7:0]  rom_di,
    output logic        rom_ready,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [15:0] dl_data,
    output logic        dl_wait,
    output logic        dl_overflow,
    input  logic        bk_req,
    input  logic        bk_we,
    input  logic [16:0] bk_addr,
    input  logic [15:0] bk_wdata,
    output logic [15:0] bk_rdata,
    output logic        bk_ack,
    gb_mem_if.master    mem
);
    state_t      state;
    grant_t      grant;
    logic [21:0] fill_tag;
    logic [23:0] dl_waddr;
    logic [15:0] dl_wdata;
    logic        rom_miss;
    logic        rom_fill;
    logic        dl_done;
    logic        unused_dl_lsb;

    assign unused_dl_lsb = dl_addr[0];

    assign rom_fill = (state == WAIT) && mem.mem_ack && (grant == G_ROM);
    assign dl_done  = (state == WAIT) && mem.mem_ack && (grant == G_DL);

    rom_word_buf u_buf (
        .clk        (clk),
        .reset      (reset),
        .rom_addr   (rom_addr),
        .rom_rd     (rom_rd),
        .fill       (rom_fill),
        .fill_tag   (fill_tag),
        .fill_word  (mem.mem_rdata),
        .inval      (dl_wr),
        .inval_addr (dl_addr[24:1]),
        .miss       (rom_miss),
        .rom_di     (rom_di),
        .rom_ready  (rom_ready)
    );

    // A strobe while the holding register is still busy is dropped and remembered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dl_wait     <= 1'b0;
            dl_overflow <= 1'b0;
            dl_waddr    <= '0;
            dl_wdata    <= '0;
        end else begin
            if (dl_wr && dl_wait) begin
                dl_overflow <= 1'b1;
            end
            if (dl_wr && !dl_wait) begin
                dl_wait  <= 1'b1;
                dl_waddr <= dl_addr[24:1];
                dl_wdata <= dl_data;
            end else if (dl_done) begin
                dl_wait <= 1'b0;
            end
        end
    end

    // NOTE: every register here uses <= so each branch sees pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            grant         <= G_ROM;
            fill_tag      <= '0;
            mem.mem_addr  <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_wdata <= '0;
            bk_rdata      <= '0;
            bk_ack        <= 1'b0;
        end else begin
            bk_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (rom_miss) begin
                        grant         <= G_ROM;
                        fill_tag      <= rom_addr[22:1];
                        mem.mem_addr  <= MEM_AW'(rom_addr[22:1]);
                        mem.mem_we    <= 1'b0;
                        state         <= ISSUE;
                    end else if (dl_wait) begin
                        grant         <= G_DL;
                        mem.mem_addr  <= MEM_AW'(dl_waddr);
                        mem.mem_we    <= 1'b1;
                        mem.mem_wdata <= dl_wdata;
                        state         <= ISSUE;
                    end else if (bk_req) begin
                        grant         <= G_BK;
                        mem.mem_addr  <= BK_BASE + MEM_AW'(bk_addr);
                        mem.mem_we    <= bk_we;
                        mem.mem_wdata <= bk_wdata;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem.mem_req <= 1'b1;
                    state       <= WAIT;
                end
                WAIT: begin
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        if (grant == G_BK) begin
                            bk_ack <= 1'b1;
                            if (!mem.mem_we) begin
                                bk_rdata <= mem.mem_rdata;
                            end
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gb_mem_arbiter.sv
// Self-checking bench: memory responder with an access scoreboard plus ROM/backup checks.
module tb_gb_mem_arbiter;
    import gb_mem_pkg::*;

    localparam int          MEM_AW  = 25;
    localparam logic [24:0] BK_BASE = 25'h1F0_0000;
    localparam int          MEM_LAT = 2;

    typedef struct packed {
        logic        we;
        logic [24:0] addr;
        logic [15:0] wdata;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [22:0] rom_addr;
    logic        rom_rd;
    logic [7:0]  rom_di;
    logic        rom_ready;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [15:0] dl_data;
    logic        dl_wait;
    logic        dl_overflow;
    logic        bk_req;
    logic        bk_we;
    logic [16:0] bk_addr;
    logic [15:0] bk_wdata;
    logic [15:0] bk_rdata;
    logic        bk_ack;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          ack_cyc = 0;
    bit          mem_en = 1'b1;
    int          stray_cnt = 0;
    acc_t        exp_acc[$];
    logic [7:0]  exp_rom[$];
    logic [15:0] mem_model[int];

    gb_mem_if #(.MEM_AW(MEM_AW)) mem ();

    gb_mem_arbiter #(.MEM_AW(MEM_AW), .BK_BASE(BK_BASE)) dut (
        .clk         (clk),
        .reset       (reset),
        .rom_addr    (rom_addr),
        .rom_rd      (rom_rd),
        .rom_di      (rom_di),
        .rom_ready   (rom_ready),
        .dl_wr       (dl_wr),
        .dl_addr     (dl_addr),
        .dl_data     (dl_data),
        .dl_wait     (dl_wait),
        .dl_overflow (dl_overflow),
        .bk_req      (bk_req),
        .bk_we       (bk_we),
        .bk_addr     (bk_addr),
        .bk_wdata    (bk_wdata),
        .bk_rdata    (bk_rdata),
        .bk_ack      (bk_ack),
        .mem         (mem)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rd_model(input int a);
        logic [31:0] v;
        if (mem_model.exists(a)) return mem_model[a];
        v = a;
        return v[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [22:0] a);
        logic [15:0] w;
        w = rd_model(int'(a[22:1]));
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    // Memory responder: acks MEM_LAT+1 negedges after seeing mem_req, checks each access.
    initial begin
        int   lat;
        int   stray_seen;
        acc_t e;
        lat = 0;
        stray_seen = 0;
        mem.mem_ack = 1'b0;
        mem.mem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            mem.mem_ack = 1'b0;
            if (stray_cnt != stray_seen) begin
                stray_seen = stray_cnt;
                mem.mem_rdata = 16'hDEAD;
                mem.mem_ack = 1'b1;
            end else if (mem_en && mem.mem_req) begin
                if (lat < MEM_LAT) begin
                    lat++;
                end else begin
                    lat = 0;
                    n_acc++;
                    ack_cyc = cyc;
                    check("acc_expected", exp_acc.size() != 0, 1);
                    if (exp_acc.size() != 0) begin
                        e = exp_acc.pop_front();
                        check("acc_we", mem.mem_we, e.we);
                        check("acc_addr", mem.mem_addr, e.addr);
                        if (e.we) check("acc_wdata", mem.mem_wdata, e.wdata);
                    end
                    if (mem.mem_we) mem_model[int'(mem.mem_addr)] = mem.mem_wdata;
                    else mem.mem_rdata = rd_model(int'(mem.mem_addr));
                    mem.mem_ack = 1'b1;
                end
            end else begin
                lat = 0;
            end
        end
    end

    task automatic rom_read(input logic [22:0] a, input logic [7:0] exp_b, input bit miss);
        int n0;
        int t;
        n0 = n_acc;
        if (miss) exp_acc.push_back('{we: 1'b0, addr: 25'(a[22:1]), wdata: 16'h0000});
        exp_rom.push_back(exp_b);
        rom_addr = a;
        rom_rd = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!rom_ready && t < 60);
        check("rom_ready_seen", rom_ready, 1);
        check("rom_di", rom_di, exp_rom.pop_front());
        if (miss) begin
            check("miss_latency", cyc - ack_cyc, 2);
            check("miss_accesses", n_acc - n0, 1);
        end else begin
            check("hit_latency", t, 1);
            check("hit_accesses", n_acc - n0, 0);
            check("hit_no_req", mem.mem_req, 0);
        end
    endtask

    task automatic dl_write(input logic [24:0] a, input logic [15:0] d, input bit accept);
        if (accept) exp_acc.push_back('{we: 1'b1, addr: 25'(a[24:1]), wdata: d});
        dl_wr = 1'b1;
        dl_addr = a;
        dl_data = d;
        @(negedge clk);
        dl_wr = 1'b0;
    endtask

    task automatic wait_dl_idle();
        int t;
        t = 0;
        while (dl_wait && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("dl_wait_clear", dl_wait, 0);
    endtask

    task automatic bk_access(input logic we, input logic [16:0] a, input logic [15:0] wd,
                             input logic [15:0] exp_rd);
        int t;
        exp_acc.push_back('{we: we, addr: BK_BASE + 25'(a), wdata: wd});
        bk_req = 1'b1;
        bk_we = we;
        bk_addr = a;
        bk_wdata = wd;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bk_ack && t < 60);
        check("bk_ack_seen", bk_ack, 1);
        if (!we) check("bk_rdata", bk_rdata, exp_rd);
        bk_req = 1'b0;
        @(negedge clk);
        check("bk_ack_one_cycle", bk_ack, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int t;
        logic seen;
        logic [7:0] pri_byte;

        reset = 1'b1;
        rom_addr = '0; rom_rd = 1'b0;
        dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        bk_req = 1'b0; bk_we = 1'b0; bk_addr = '0; bk_wdata = '0;
        repeat (3) @(negedge clk);

        check("rst_mem_req", mem.mem_req, 0);
        check("rst_mem_we", mem.mem_we, 0);
        check("rst_mem_addr", mem.mem_addr, 0);
        check("rst_mem_wdata", mem.mem_wdata, 0);
        check("rst_bk_ack", bk_ack, 0);
        check("rst_bk_rdata", bk_rdata, 0);
        check("rst_dl_wait", dl_wait, 0);
        check("rst_dl_overflow", dl_overflow, 0);
        check("rst_rom_ready", rom_ready, 0);
        check("rst_rom_di", rom_di, 0);
        reset = 1'b0;
        @(negedge clk);

        // Miss on word 0x80, then the other byte of the same word hits
        mem_model[32'h80] = 16'hBEEF;
        rom_read(23'h000100, 8'hEF, 1'b1);
        rom_read(23'h000101, 8'hBE, 1'b0);

        // Download to the buffered word invalidates it; re-read fetches new data
        rom_rd = 1'b0;
        dl_write(25'h000100, 16'h1234, 1'b1);
        wait_dl_idle();
        rom_read(23'h000100, 8'h34, 1'b1);
        rom_read(23'h000101, 8'h12, 1'b0);

        // ROM miss, download and backup pending together: ROM, DL, BK order
        n0 = n_acc;
        pri_byte = exp_byte(23'h002468);
        exp_acc.push_back('{we: 1'b0, addr: 25'h1234, wdata: 16'h0000});
        exp_acc.push_back('{we: 1'b1, addr: 25'h0200, wdata: 16'h7777});
        exp_acc.push_back('{we: 1'b0, addr: BK_BASE + 25'h5, wdata: 16'h0000});
        rom_addr = 23'h002468; rom_rd = 1'b1;
        dl_wr = 1'b1; dl_addr = 25'h000400; dl_data = 16'h7777;
        bk_req = 1'b1; bk_we = 1'b0; bk_addr = 17'h5;
        @(negedge clk);
        dl_wr = 1'b0;
        t = 0;
        while (!bk_ack && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("pri_bk_ack_seen", bk_ack, 1);
        check("pri_bk_rdata", bk_rdata, 16'h5A5A ^ 16'h0005);
        bk_req = 1'b0;
        @(negedge clk);
        check("pri_accesses", n_acc - n0, 3);
        check("pri_rom_ready", rom_ready, 1);
        check("pri_rom_di", rom_di, pri_byte);
        rom_rd = 1'b0;

        // Strobe in the same cycle as the previous download's mem_ack is an overflow
        dl_write(25'h001000, 16'h1111, 1'b1);
        t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (!mem.mem_ack && t < 60);
        check("dl_ack_seen", mem.mem_ack, 1);
        n0 = n_acc;
        dl_write(25'h001002, 16'h2222, 1'b0);
        check("ovf_on_ack", dl_overflow, 1);
        repeat (12) @(negedge clk);
        check("ovf_on_ack_no_access", n_acc - n0, 0);
        check("ovf_on_ack_not_written", mem_model.exists(32'h801), 0);

        // Backup read, then a write/read pair at the top of the backup window
        mem_model[int'(BK_BASE + 25'h10)] = 16'hCAFE;
        bk_access(1'b0, 17'h00010, 16'h0000, 16'hCAFE);
        bk_access(1'b1, 17'h1FFFF, 16'h55AA, 16'h0000);
        bk_access(1'b0, 17'h1FFFF, 16'h0000, 16'h55AA);
        check("ovf_sticky", dl_overflow, 1);

        // Reset while WAIT: request drops at once, later stray ack is ignored
        mem_en = 1'b0;
        rom_addr = 23'h003000; rom_rd = 1'b1;
        t = 0;
        while (!mem.mem_req && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("rstw_req_raised", mem.mem_req, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rstw_req_dropped", mem.mem_req, 0);
        check("rstw_ovf_cleared", dl_overflow, 0);
        rom_rd = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mem_en = 1'b1;
        stray_cnt++;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | bk_ack | mem.mem_req;
        end
        check("stray_ack_ignored", seen, 0);
        rom_read(23'h003000, exp_byte(23'h003000), 1'b1);
        rom_rd = 1'b0;

        // Two strobes back to back: the first lands, the second is dropped
        @(negedge clk);
        check("ovf_clear_before", dl_overflow, 0);
        dl_write(25'h000800, 16'hAAAA, 1'b1);
        dl_write(25'h000802, 16'hBBBB, 1'b0);
        check("ovf_b2b", dl_overflow, 1);
        wait_dl_idle();
        repeat (12) @(negedge clk);
        check("ovf_b2b_sticky", dl_overflow, 1);
        check("ovf_b2b_dropped", mem_model.exists(32'h401), 0);
        check("scoreboard_drained", exp_acc.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
